// File: rtl/mac_job_sequencer_if.sv
// rtl/mac_job_sequencer_if.sv - operand issue, result input and result output handshake bundle
//
// Ports (slave = sequencer side):
//   op_valid/op_ready      operand-pair handshake from the upstream source
//   mac_en/mac_first/mac_last  issue strobe and accumulator tags to the MAC
//   res_sign/res_norm/res_exp  normalization-stage result from the MAC pipeline
//   out_valid/out_ready    captured-result handshake to the consumer
//   out_sign/out_norm/out_exp  captured result
interface mac_job_sequencer_if;
    logic        op_valid;
    logic        op_ready;
    logic        mac_en;
    logic        mac_first;
    logic        mac_last;
    logic        res_sign;
    logic [10:0] res_norm;
    logic [6:0]  res_exp;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [10:0] out_norm;
    logic [6:0]  out_exp;

    modport slave (
        input  op_valid, res_sign, res_norm, res_exp, out_ready,
        output op_ready, mac_en, mac_first, mac_last,
               out_valid, out_sign, out_norm, out_exp
    );

    modport master (
        output op_valid, res_sign, res_norm, res_exp, out_ready,
        input  op_ready, mac_en, mac_first, mac_last,
               out_valid, out_sign, out_norm, out_exp
    );
endinterface

// File: rtl/mac_job_sequencer.sv
// rtl/mac_job_sequencer.sv - sequences one dot-product job through the MAC pipeline and captures its result
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     job start pulse, sampled only when idle
//   cfg_len   job length minus one, latched at start
//   abort     synchronous job cancel
//   busy      high whenever a job is in progress
//   elem_cnt  number of elements issued so far in the current job
//   bus       operand/result handshakes (slave side of mac_job_sequencer_if)
// LAT is the MAC pipeline latency in edges from issue to res_* valid (2..8).
module mac_job_sequencer #(
    parameter int LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           cfg_len,
    input  logic                 abort,
    output logic                 busy,
    output logic [7:0]           elem_cnt,
    mac_job_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [7:0]     len_q;
    // One-hot-in-time marker following the last element down the MAC pipeline.
    logic [LAT-1:0] tag;
    logic           issue;
    logic           last_issue;

    assign busy          = (state != IDLE);
    assign bus.op_ready  = (state == ISSUE);
    // An abort voids any handshake in the same cycle.
    assign issue         = bus.op_valid & bus.op_ready & ~abort;
    assign last_issue    = issue & (elem_cnt == len_q);
    assign bus.mac_en    = issue;
    assign bus.mac_first = issue & (elem_cnt == 8'd0);
    assign bus.mac_last  = last_issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            len_q         <= 8'd0;
            elem_cnt      <= 8'd0;
            tag           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sign  <= 1'b0;
            bus.out_norm  <= 11'd0;
            bus.out_exp   <= 7'd0;
        end else if (abort && (state != IDLE)) begin
            state         <= IDLE;
            elem_cnt      <= 8'd0;
            tag           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            tag <= {tag[LAT-2:0], last_issue};
            // Wraps on a 256-element job's final issue; the FSM leaves ISSUE then.
            if (issue) begin
                elem_cnt <= elem_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= cfg_len;
                        elem_cnt <= 8'd0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // res_* holds the final result in the cycle tag reaches the end.
                    if (tag[LAT-1]) begin
                        bus.out_sign  <= bus.res_sign;
                        bus.out_norm  <= bus.res_norm;
                        bus.out_exp   <= bus.res_exp;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb/tb_mac_job_sequencer.sv - randomized scoreboard bench for mac_job_sequencer
module tb_mac_job_sequencer;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_len = 8'd0;
    logic       abort = 1'b0;
    logic       busy;
    logic [7:0] elem_cnt;

    mac_job_sequencer_if bus();

    mac_job_sequencer #(.LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .abort    (abort),
        .busy     (busy),
        .elem_cnt (elem_cnt),
        .bus      (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        exp_busy = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_ov = 1'b0;
    logic [9:0]  iss_q[$];
    logic [18:0] res_q[$];
    logic [18:0] hist[0:63];

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Fresh random normalization result every cycle, recorded by cycle index.
    always @(negedge clk) begin
        #1;
        {bus.res_sign, bus.res_norm, bus.res_exp} = 19'($urandom);
        hist[cyc % 64] = {bus.res_sign, bus.res_norm, bus.res_exp};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT behaviour against expectations pushed by the stimulus.
    logic        prev_ov = 1'b0;
    logic [18:0] held;
    logic [9:0]  e_iss;
    logic [18:0] e_res;
    always @(negedge clk) begin
        if (rst) begin
            chk("busy", busy, exp_busy);
            chk("op_ready", bus.op_ready, exp_ready);
            chk("out_valid", bus.out_valid, exp_ov);
            if (bus.mac_en) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue got mac_en=1 want 0 at cycle %0d", cyc);
                end else begin
                    e_iss = iss_q.pop_front();
                    chk("mac_first", bus.mac_first, e_iss[9]);
                    chk("mac_last", bus.mac_last, e_iss[8]);
                    chk("elem_cnt_at_issue", elem_cnt, e_iss[7:0]);
                end
            end else begin
                chk("tags_without_issue", {bus.mac_first, bus.mac_last}, 0);
            end
            if (bus.out_valid && !prev_ov) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got out_valid=1 want 0 at cycle %0d", cyc);
                end else begin
                    e_res = res_q.pop_front();
                    chk("out_data", {bus.out_sign, bus.out_norm, bus.out_exp}, e_res);
                end
                held = {bus.out_sign, bus.out_norm, bus.out_exp};
            end else if (bus.out_valid) begin
                chk("out_stable", {bus.out_sign, bus.out_norm, bus.out_exp}, held);
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_op_ready"}, bus.op_ready, 0);
        chk({tag, "_mac"}, {bus.mac_en, bus.mac_first, bus.mac_last}, 0);
        chk({tag, "_elem_cnt"}, elem_cnt, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, {bus.out_sign, bus.out_norm, bus.out_exp}, 0);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge.
    task automatic do_reset();
        bus.op_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        exp_busy = 1'b0;
        exp_ready = 1'b0;
        exp_ov = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        bus.op_valid = 1'b0;
        bus.out_ready = 1'b0;
        iss_q.delete();
        res_q.delete();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // mode: 0 normal, 1 abort in DRAIN, 2 reset in DRAIN, 3 reset in DONE
    task automatic run_job(input int len, input int gap_pct, input int od, input int abort_at, input int mode);
        int idx;
        int c0;
        int guard;
        bus.out_ready = 1'b0;
        start = 1'b1;
        cfg_len = 8'(len);
        step();
        start = 1'b0;
        cfg_len = 8'($urandom);
        exp_busy = 1'b1;
        exp_ready = 1'b1;
        idx = 0;
        c0 = 0;
        guard = 0;
        while (idx <= len) begin
            if (idx == abort_at) begin
                abort = 1'b1;
                bus.op_valid = 1'($urandom);
                step();
                abort = 1'b0;
                bus.op_valid = 1'b0;
                exp_busy = 1'b0;
                exp_ready = 1'b0;
                chk("abort_issue_elem_cnt", elem_cnt, 0);
                chk("abort_issue_pending", iss_q.size(), 0);
                repeat (LAT + 2) step();
                return;
            end
            bus.op_valid = ($urandom_range(99) >= gap_pct);
            if (bus.op_valid) begin
                iss_q.push_back({idx == 0, idx == len, 8'(idx)});
                if (idx == len) c0 = cyc;
                idx++;
            end
            step();
            guard++;
            if (guard > 4000) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout got %0d issued want %0d", idx, len + 1);
                return;
            end
        end
        exp_ready = 1'b0;
        chk("elem_cnt_after_last", elem_cnt, 8'(len + 1));
        chk("issues_all_seen", iss_q.size(), 0);
        while (cyc < c0 + LAT + 1) begin
            bus.op_valid = 1'($urandom);
            start = 1'($urandom);
            if (mode == 1 && cyc == c0 + 2) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                start = 1'b0;
                bus.op_valid = 1'b0;
                exp_busy = 1'b0;
                chk("abort_drain_elem_cnt", elem_cnt, 0);
                repeat (LAT + 2) step();
                return;
            end
            if (mode == 2 && cyc == c0 + 2) begin
                do_reset();
                return;
            end
            step();
        end
        // Capture edge ends cycle c0+LAT; result sampled from that cycle.
        exp_ov = 1'b1;
        res_q.push_back(hist[(c0 + LAT) % 64]);
        start = 1'($urandom);
        bus.op_valid = 1'($urandom);
        if (mode == 3) begin
            step();
            do_reset();
            return;
        end
        for (int k = 0; k < od; k++) begin
            step();
            start = 1'($urandom);
            bus.op_valid = 1'($urandom);
        end
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_valid = 1'b0;
        exp_ov = 1'b0;
        exp_busy = 1'b0;
    endtask

    initial begin
        #1000000;
        checks++;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int len;
        bus.op_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        step();
        run_job(0, 0, 0, -1, 0);
        run_job(3, 0, 1, -1, 0);
        run_job(2, 50, 0, -1, 0);
        run_job(5, 20, 10, -1, 0);
        run_job(4, 0, 0, 2, 0);
        run_job(3, 30, 2, -1, 0);
        run_job(3, 0, 0, -1, 1);
        run_job(1, 0, 0, -1, 0);
        run_job(6, 25, 0, -1, 2);
        run_job(2, 0, 0, -1, 3);
        run_job(255, 0, 1, -1, 0);
        for (int i = 0; i < 25; i++) begin
            len = $urandom_range(40);
            run_job(len, $urandom_range(60), $urandom_range(5),
                    ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1, 0);
        end
        repeat (LAT + 3) step();
        chk("final_issue_q", iss_q.size(), 0);
        chk("final_res_q", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_job_sequencer.md
# mac_job_sequencer

Control block that sequences one dot-product job through the 4-stage SD4 MAC pipeline ending in the normalization stage. It accepts a job length, paces operand-pair issue from an upstream source with a valid/ready handshake, and tags the first and last element for the MAC accumulator. It tracks the last element through the fixed-latency pipeline, then captures the normalized result (sign, mantissa, exponent) into an output holding register with its own valid/ready handshake. Operand data flows directly from the source to the MAC; this block owns only control and the final result capture.

## Interface
- LAT, 4: MAC pipeline latency in clock edges, from the operand-issue edge to the result being valid on res_*. Legal range 2..8.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- cfg_len  in  8  job length minus one; a job has cfg_len+1 elements (1..256)
- abort  in  1  synchronous job cancel
- busy  out  1  high in any state other than IDLE
- op_valid  in  1  source has an operand pair on the MAC inputs
- op_ready  out  1  sequencer accepts a pair this cycle
- mac_en  out  1  issue strobe, equal to op_valid & op_ready
- mac_first  out  1  issued pair is element 0 (clears the accumulator)
- mac_last  out  1  issued pair is element cfg_len
- elem_cnt  out  8  number of elements issued so far in the current job
- res_sign  in  1  normalization-stage sign
- res_norm  in  11  normalization-stage mantissa
- res_exp  in  7  normalization-stage exponent (signed)
- out_valid  out  1  captured result available
- out_ready  in  1  consumer accepts the result
- out_sign  out  1  captured sign
- out_norm  out  11  captured mantissa
- out_exp  out  7  captured exponent (signed)

## Operation
- Four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - When start=1, latch cfg_len into len_q, clear elem_cnt, and go to ISSUE.
  - When start=0, remain in IDLE.
- ISSUE:
  - op_ready=1 (combinational on state).
  - Each handshake increments elem_cnt.
  - mac_first = mac_en & (elem_cnt==0).
  - mac_last = mac_en & (elem_cnt==len_q).
  - A handshake with mac_last=1 moves the FSM to DRAIN.
  - op_valid gaps are allowed and simply stall issue.
- Last-tag shift register tag[LAT-1:0]:
  - Shifts every cycle. tag[0] loads mac_last.
  - tag[LAT-1]=1 marks res_* as holding the final job result.
  - In DRAIN, tag[LAT-1]=1 causes the next edge to capture res_* into out_* and move to DONE.
- DONE:
  - out_valid=1 and out_* held stable until out_valid & out_ready, then go to IDLE.
- Restrictions:
  - op_ready=0 in DRAIN, DONE and IDLE.
  - start is ignored outside IDLE.
  - cfg_len changes after the start edge have no effect.
- abort, in any non-IDLE state:
  - Next edge goes to IDLE, clears tag, out_valid and elem_cnt.
  - Any handshake in that same cycle is void: mac_en is forced to 0 while abort=1.
  - abort takes priority over start, capture and out handshake.
- Widths:
  - elem_cnt is 8 bits. It reaches len_q at the last issue, and the increment on the last issue wraps (255+1 → 0), which is harmless because the FSM leaves ISSUE.
  - out_exp is a pass-through copy and is not reinterpreted.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - busy, op_ready, mac_en, mac_first and mac_last are all 0.
  - elem_cnt=0, tag=0.
  - out_valid=0, out_sign=0, out_norm=0, out_exp=0.
  - Reset mid-job drops the job entirely.
- Start to issue: a start edge E_s gives busy=1 and op_ready=1 in the cycle after E_s.
- Issue to result:
  - The last pair is issued at edge E0.
  - tag[LAT-1]=1 after edge E0+LAT-1.
  - Capture happens at E0+LAT, so out_valid=1 after E0+LAT.
- Result consumption: the out handshake at edge E_o gives out_valid=0, busy=0 and state IDLE after E_o. A new start is accepted from the cycle after E_o.
- Minimum job time for N elements with no stalls: 1 + N + LAT edges from start to out_valid, then at least 1 edge for the handshake.
- Back-to-back issue is allowed every cycle. The MAC tolerates single-cycle accumulation feedback.

## Test plan
- Single element:
  - Stimulus: cfg_len=0, op_valid held high, LAT=4.
  - Response: one mac_en pulse with mac_first=mac_last=1. out_valid rises 4 edges after the issue edge with out_*=res_* sampled at that edge (e.g. sign=1, norm=0x400, exp=-3).
- Four elements, no stalls:
  - Stimulus: cfg_len=3, op_valid=1 continuously.
  - Response: 4 consecutive mac_en pulses; mac_first on #0, mac_last on #3, elem_cnt steps 1..4. out_valid comes 4 edges after the last issue and busy stays 1 until the out handshake.
- Source gaps:
  - Stimulus: cfg_len=2, op_valid pattern 1,0,0,1,0,1.
  - Response: exactly 3 issues with elem_cnt 1,2,3; no issue in DRAIN even with op_valid=1.
- Output backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Response: out_* stable and op_ready=0 throughout. A start in this window is ignored. IDLE is reached one edge after out_ready=1.
- Abort:
  - Stimulus: abort in ISSUE after 2 of 5 elements, and separately abort in DRAIN with tag[1]=1.
  - Response: IDLE next edge, elem_cnt=0, no out_valid pulse ever, and the following job behaves normally.
- Async reset:
  - Stimulus: rst=0 mid-DRAIN and mid-DONE.
  - Response: all outputs reach their reset values immediately, without a clock edge. After release, start with cfg_len=255 issues exactly 256 elements with elem_cnt wrapping to 0 on the last issue.
